// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Default timing is 1280x960@60 with a 108 MHz pixel clock.
package vga_timing_pkg;

    // Width of both raster counters; totals must fit in this range.
    localparam int unsigned COUNT_W   = 12;
    localparam int unsigned MAX_TOTAL = 4096;

    // Default horizontal timing (pixels).
    localparam int unsigned H_ACTIVE_DEF = 1280;
    localparam int unsigned H_FP_DEF     = 96;
    localparam int unsigned H_SYNC_DEF   = 112;
    localparam int unsigned H_BP_DEF     = 312;

    // Default vertical timing (lines).
    localparam int unsigned V_ACTIVE_DEF = 960;
    localparam int unsigned V_FP_DEF     = 1;
    localparam int unsigned V_SYNC_DEF   = 3;
    localparam int unsigned V_BP_DEF     = 36;

    // Raster coordinate type used by consumers of the counts.
    typedef logic [COUNT_W-1:0] count_t;

    // Snapshot of one raster position with its decoded qualifiers.
    typedef struct packed {
        count_t h;
        count_t v;
        logic   display_en;
        logic   h_sync;
        logic   v_sync;
        logic   line_start;
        logic   frame_start;
    } raster_pos_t;

    // Period of one axis: active region plus the three blanking segments.
    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    // Pixels per line including blanking.
    function automatic int unsigned h_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return axis_total(active, fp, sync, bp);
    endfunction

    // Lines per frame including blanking.
    function automatic int unsigned v_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: modulo counter with increment enable and wrap output,
// plus the active-region and sync-window decode of the *next* count so the
// parent can register flags in the same cycle as the count itself.
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned FP       = H_FP_DEF,
    parameter int unsigned SYNC     = H_SYNC_DEF,
    parameter int unsigned BP       = H_BP_DEF,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               upd_i,
    input  logic               inc_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               sync_o,
    output logic               wrap_o,
    output logic               next_active_o,
    output logic               next_zero_o
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    // Window bounds are compared one bit wider so an end bound equal to
    // MAX_TOTAL cannot alias back to zero.
    localparam int unsigned EXT_W = COUNT_W + 1;

    localparam logic [COUNT_W-1:0] LAST_C       = COUNT_W'(TOTAL - 1);
    localparam logic [EXT_W-1:0]   ACT_END_C    = EXT_W'(ACTIVE);
    localparam logic [EXT_W-1:0]   SYNC_BEG_C   = EXT_W'(ACTIVE + FP);
    localparam logic [EXT_W-1:0]   SYNC_END_C   = EXT_W'(ACTIVE + FP + SYNC);
    localparam logic               SYNC_ON_C    = SYNC_POL;
    localparam logic               SYNC_OFF_C   = ~SYNC_POL;

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               sync_q;
    logic               sync_d;
    logic [EXT_W-1:0]   count_ext_s;
    logic               at_last_s;

    assign at_last_s = (count_q == LAST_C);

    // Next count: increment modulo TOTAL when enabled, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            if (at_last_s) begin
                count_d = {COUNT_W{1'b0}};
            end else begin
                count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_d = count_q;
        end
    end

    assign count_ext_s = {1'b0, count_d};

    // Decode region membership of the next count for same-cycle registration.
    always_comb begin
        next_active_o = 1'b0;
        next_zero_o   = 1'b0;
        sync_d        = SYNC_OFF_C;
        next_active_o = (count_ext_s < ACT_END_C);
        next_zero_o   = (count_d == {COUNT_W{1'b0}});
        if ((count_ext_s >= SYNC_BEG_C) && (count_ext_s < SYNC_END_C)) begin
            sync_d = SYNC_ON_C;
        end else begin
            sync_d = SYNC_OFF_C;
        end
    end

    // Wrap only reported when the counter actually rolls over this edge.
    assign wrap_o = inc_i & at_last_s;

    // Count and sync register; reset parks at zero with sync inactive.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= {COUNT_W{1'b0}};
            sync_q  <= SYNC_OFF_C;
        end else if (upd_i) begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end else begin
            count_q <= count_q;
            sync_q  <= sync_q;
        end
    end

    assign count_o = count_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, active-video qualifier,
// HSYNC/VSYNC and line/frame markers, all registered with zero skew.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter bit          H_SYNC_POL = 1'b1,
    parameter bit          V_SYNC_POL = 1'b1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               pix_ce,
    output logic [COUNT_W-1:0] h_count,
    output logic [COUNT_W-1:0] v_count,
    output logic               display_en,
    output logic               h_sync,
    output logic               v_sync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Refuse to build a raster the 12-bit counters cannot represent.
    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_too_big
        $error("vga_timing_gen: H_TOTAL exceeds counter range");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_too_big
        $error("vga_timing_gen: V_TOTAL exceeds counter range");
    end

    logic primed_q;
    logic primed_d;
    logic h_inc_s;
    logic h_wrap_s;
    logic v_inc_s;
    logic v_wrap_s;
    logic h_next_active_s;
    logic h_next_zero_s;
    logic v_next_active_s;
    logic v_next_zero_s;

    logic display_en_q;
    logic display_en_d;
    logic line_start_q;
    logic line_start_d;
    logic frame_start_q;
    logic frame_start_d;

    // The first enabled edge after reset only primes: position stays (0,0)
    // so the pattern stage sees pixel 0 with its markers before any advance.
    always_comb begin
        primed_d = primed_q;
        if (pix_ce) begin
            primed_d = 1'b1;
        end else begin
            primed_d = primed_q;
        end
    end

    assign h_inc_s = pix_ce & primed_q;
    assign v_inc_s = h_wrap_s & pix_ce;

    // Priming flag register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            primed_q <= 1'b0;
        end else begin
            primed_q <= primed_d;
        end
    end

    timing_axis #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (H_SYNC_POL)
    ) u_h_axis (
        .clk_i         (clk_in),
        .reset_i       (reset),
        .upd_i         (pix_ce),
        .inc_i         (h_inc_s),
        .count_o       (h_count),
        .sync_o        (h_sync),
        .wrap_o        (h_wrap_s),
        .next_active_o (h_next_active_s),
        .next_zero_o   (h_next_zero_s)
    );

    // Vertical axis steps only on the horizontal wrap, so its sync edges
    // coincide with h_count returning to zero.
    timing_axis #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (V_SYNC_POL)
    ) u_v_axis (
        .clk_i         (clk_in),
        .reset_i       (reset),
        .upd_i         (pix_ce),
        .inc_i         (v_inc_s),
        .count_o       (v_count),
        .sync_o        (v_sync),
        .wrap_o        (v_wrap_s),
        .next_active_o (v_next_active_s),
        .next_zero_o   (v_next_zero_s)
    );

    // Combine per-axis next-position decodes into the joint raster flags.
    always_comb begin
        display_en_d  = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        display_en_d  = h_next_active_s & v_next_active_s;
        line_start_d  = h_next_zero_s;
        frame_start_d = h_next_zero_s & v_next_zero_s;
    end

    // Joint flags registered on the same enable as the counts.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            display_en_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_ce) begin
            display_en_q  <= display_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end else begin
            display_en_q  <= display_en_q;
            line_start_q  <= line_start_q;
            frame_start_q <= frame_start_q;
        end
    end

    assign display_en  = display_en_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Horizontal timing is the default
// 1800-pixel line; the frame is shortened to 12 lines to keep runs short.
module tb_vga_timing_gen;

    localparam int HA = 1280, HFP = 96, HS = 112, HBP = 312;
    localparam int VA = 6,    VFP = 1,  VS = 3,   VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;   // 1800
    localparam int VT = VA + VFP + VS + VBP;   // 12
    localparam bit HPOL = 1'b1;
    localparam bit VPOL = 1'b1;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        pix_ce = 1'b1;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic        display_en, h_sync, v_sync, line_start, frame_start;

    int tests = 0;
    int fails = 0;

    // Reference raster position, advanced from the input rules alone.
    int m_h = 0;
    int m_v = 0;
    bit m_primed = 1'b0;
    bit m_live   = 1'b0;
    bit m_valid  = 1'b0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .h_count     (h_count),
        .v_count     (v_count),
        .display_en  (display_en),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk_in = ~clk_in;

    // Model position update on every clock edge.
    always @(posedge clk_in) begin
        if (reset) begin
            m_h      <= 0;
            m_v      <= 0;
            m_primed <= 1'b0;
            m_live   <= 1'b0;
            m_valid  <= 1'b1;
        end else if (pix_ce) begin
            m_primed <= 1'b1;
            m_live   <= 1'b1;
            if (m_primed) begin
                if (m_h == HT - 1) begin
                    m_h <= 0;
                    m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h <= m_h + 1;
                end
            end
        end
    end

    // Expected output vector for a position, straight from the raster rules.
    function automatic logic [28:0] model_vec(input int h, input int v, input bit live);
        logic de, hs, vs, ls, fs;
        if (!live) return {12'd0, 12'd0, 1'b0, ~HPOL, ~VPOL, 1'b0, 1'b0};
        de = (h < HA) && (v < VA);
        hs = ((h >= HA + HFP) && (h < HA + HFP + HS)) ? HPOL : ~HPOL;
        vs = ((v >= VA + VFP) && (v < VA + VFP + VS)) ? VPOL : ~VPOL;
        ls = (h == 0);
        fs = (h == 0) && (v == 0);
        return {12'(h), 12'(v), de, hs, vs, ls, fs};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Advance n cycles; at each falling edge compare the DUT with the model.
    task automatic step(input int n);
        logic [28:0] got, exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (m_valid) begin
                got = {h_count, v_count, display_en, h_sync, v_sync, line_start, frame_start};
                exp = model_vec(m_h, m_v, m_live);
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL model_cmp t=%0t got=%h exp=%h (h=%0d v=%0d)",
                             $time, got, exp, m_h, m_v);
                end
            end
        end
    endtask

    int de_cnt, hs_cnt, vs_cnt, fs_cnt, ls_cnt, de_bad, vs_bad;
    logic prev_vs;

    initial begin
        // Reset held five cycles with the enable high.
        reset  = 1'b1;
        pix_ce = 1'b1;
        step(5);
        chk("rst_h", h_count, 0);
        chk("rst_v", v_count, 0);
        chk("rst_de", display_en, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ls", line_start, 0);
        chk("rst_hs", h_sync, 0);
        chk("rst_vs", v_sync, 0);

        // Priming edge keeps (0,0) and raises the markers.
        reset = 1'b0;
        step(1);
        chk("prime_h", h_count, 0);
        chk("prime_v", v_count, 0);
        chk("prime_de", display_en, 1);
        chk("prime_ls", line_start, 1);
        chk("prime_fs", frame_start, 1);
        step(1);
        chk("adv_h", h_count, 1);
        chk("adv_fs", frame_start, 0);

        // HSYNC window edges.
        step(1374);
        chk("h1375", h_count, 1375);
        chk("hs_pre", h_sync, 0);
        step(1);
        chk("hs_on", h_sync, 1);
        step(111);
        chk("h1487", h_count, 1487);
        chk("hs_last", h_sync, 1);
        step(1);
        chk("hs_off", h_sync, 0);
        step(311);
        chk("h1799", h_count, 1799);
        chk("v_before_wrap", v_count, 0);
        chk("de_blank", display_en, 0);
        step(1);
        chk("hwrap_h", h_count, 0);
        chk("hwrap_v", v_count, 1);
        chk("hwrap_ls", line_start, 1);
        chk("hwrap_fs", frame_start, 0);

        // One full frame starting at (0,1): aggregate counts.
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; ls_cnt = 0;
        de_bad = 0; vs_bad = 0;
        prev_vs = v_sync;
        for (int i = 0; i < HT * VT; i++) begin
            if (display_en) de_cnt++;
            if (h_sync) hs_cnt++;
            if (v_sync) vs_cnt++;
            if (frame_start) fs_cnt++;
            if (line_start) ls_cnt++;
            if (display_en && (h_count >= 12'(HA) || v_count >= 12'(VA))) de_bad++;
            if ((v_sync !== prev_vs) && (h_count != 12'd0)) vs_bad++;
            prev_vs = v_sync;
            step(1);
        end
        chk("frame_de", de_cnt, 7680);
        chk("frame_hs", hs_cnt, 1344);
        chk("frame_vs", vs_cnt, 5400);
        chk("frame_fs", fs_cnt, 1);
        chk("frame_ls", ls_cnt, 12);
        chk("de_outside", de_bad, 0);
        chk("vs_misalign", vs_bad, 0);
        chk("frame_end_h", h_count, 0);
        chk("frame_end_v", v_count, 1);

        // Clock-enable pattern 1,0,0,1 across a line boundary.
        step(1799);
        chk("ce_pre_h", h_count, 1799);
        step(1);
        chk("ce1_h", h_count, 0);
        chk("ce1_v", v_count, 2);
        chk("ce1_ls", line_start, 1);
        pix_ce = 1'b0;
        step(1);
        chk("ce0a_h", h_count, 0);
        chk("ce0a_ls", line_start, 1);
        step(1);
        chk("ce0b_h", h_count, 0);
        chk("ce0b_ls", line_start, 1);
        pix_ce = 1'b1;
        step(1);
        chk("ce1b_h", h_count, 1);
        chk("ce1b_ls", line_start, 0);

        // Mid-frame reset at (700,5), asserted with the enable low.
        step(3 * HT + 699);
        chk("mid_h", h_count, 700);
        chk("mid_v", v_count, 5);
        reset  = 1'b1;
        pix_ce = 1'b0;
        step(1);
        chk("mrst_h", h_count, 0);
        chk("mrst_v", v_count, 0);
        chk("mrst_fs", frame_start, 0);
        chk("mrst_vs", v_sync, 0);
        reset = 1'b0;
        step(2);
        chk("mhold_fs", frame_start, 0);
        chk("mhold_de", display_en, 0);
        pix_ce = 1'b1;
        step(1);
        chk("mprime_h", h_count, 0);
        chk("mprime_v", v_count, 0);
        chk("mprime_fs", frame_start, 1);
        chk("mprime_vs", v_sync, 0);
        step(1);
        chk("mrun_h", h_count, 1);
        step(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
